dtcm_ctrl: RTL and testbench

//  Responder end of the LSU-to-DTCM command/response interface. Accepts one

---
 rtl/dtcm_ctrl_pkg.sv | 14 +
 rtl/dtcm_ram.sv | 33 +++
 rtl/dtcm_ctrl.sv | 76 +++++++
 tb/tb_dtcm_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dtcm_ctrl_pkg.sv
// Shared widths and pipeline state for the LSU-facing DTCM responder.
// XLEN is 32 and the DTCM word address is 8 bits in this build.
package dtcm_ctrl_pkg;

   localparam int DTCM_DW = 32;
   localparam int DTCM_AW = 8;

   // The state register doubles as rsp_valid_q, so RSP_PEND must encode as 1.
   typedef enum logic {
      IDLE     = 1'b0,
      RSP_PEND = 1'b1
   } dtcm_state_e;

endpackage

// File: rtl/dtcm_ram.sv
// Single-port DTCM SRAM model: byte-enabled write and registered read.
// The read register only loads on a read access, so its output holds otherwise.
module dtcm_ram
   import dtcm_ctrl_pkg::*;
#(
   parameter int DW    = DTCM_DW,
   parameter int AW    = DTCM_AW,
   parameter int DEPTH = 1 << AW
) (
   input  logic            clk,
   input  logic            en,
   input  logic            we,
   input  logic [DW/8-1:0] be,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   wdata,
   output logic [DW-1:0]   rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < DW/8; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dtcm_ctrl.sv
// LSU-to-DTCM responder: one in-order response per command, one cycle after fire.
// A single response slot; a new command may fire as the pending response fires.
module dtcm_ctrl
   import dtcm_ctrl_pkg::*;
#(
   parameter int DW    = DTCM_DW,
   parameter int AW    = DTCM_AW,
   parameter int DEPTH = 1 << AW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dtcm_cmd_valid,
   output logic            dtcm_cmd_ready,
   input  logic            dtcm_cmd_read,
   input  logic [AW-1:0]   dtcm_cmd_addr,
   input  logic [DW-1:0]   dtcm_cmd_wdata,
   input  logic [DW/8-1:0] dtcm_cmd_wmask,
   output logic            dtcm_rsp_valid,
   input  logic            dtcm_rsp_ready,
   output logic [DW-1:0]   dtcm_rsp_rdata
);

   dtcm_state_e   state_q, state_d;
   logic          is_read_q;
   logic          cmd_fire;
   logic          rsp_fire;
   logic          ram_en;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;

   assign dtcm_rsp_valid = (state_q == RSP_PEND);
   assign dtcm_cmd_ready = ~dtcm_rsp_valid | dtcm_rsp_ready;
   assign cmd_fire       = dtcm_cmd_valid & dtcm_cmd_ready;
   assign rsp_fire       = dtcm_rsp_valid & dtcm_rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         is_read_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cmd_fire) is_read_q <= dtcm_cmd_read;
      end
   end

   always_comb begin
      state_d = state_q;
      ram_en  = 1'b0;
      ram_we  = 1'b0;
      if (cmd_fire) begin
         state_d = RSP_PEND;
         ram_en  = 1'b1;
         ram_we  = ~dtcm_cmd_read;
      end else if (rsp_fire) begin
         state_d = IDLE;
      end
   end

   dtcm_ram #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .be    (dtcm_cmd_wmask),
      .addr  (dtcm_cmd_addr),
      .wdata (dtcm_cmd_wdata),
      .rdata (ram_rdata)
   );

   // is_read_q resets to 0, so rdata reads as zero the instant reset asserts.
   assign dtcm_rsp_rdata = is_read_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Self-checking bench for dtcm_ctrl: directed vector table, corner sequences,
// and randomized valid/ready traffic against a word-array memory model.
module tb_dtcm_ctrl;
   import dtcm_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_read;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wmask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mdl [256];
   logic [31:0] expq [$];

   typedef struct {
      logic        rd;
      logic [7:0]  addr;
      logic [31:0] wd;
      logic [3:0]  wm;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   dtcm_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .dtcm_cmd_valid (cmd_valid),
      .dtcm_cmd_ready (cmd_ready),
      .dtcm_cmd_read  (cmd_read),
      .dtcm_cmd_addr  (cmd_addr),
      .dtcm_cmd_wdata (cmd_wdata),
      .dtcm_cmd_wmask (cmd_wmask),
      .dtcm_rsp_valid (rsp_valid),
      .dtcm_rsp_ready (rsp_ready),
      .dtcm_rsp_rdata (rsp_rdata)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference write: byte lanes with a set mask bit take the new data.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] wm);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // One isolated command with rsp_ready held high; response expected next cycle.
   task automatic txn(input logic rd, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] wm, input logic [31:0] exp, input string nm);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (!rd) mdl[a] = merge(mdl[a], wd, wm);
      chk({nm, "_vld"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_dat"}, rsp_rdata, exp);
      @(posedge clk); #1;
      chk({nm, "_idle"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        hold, cf, rf, stalled;
      logic [31:0] prev_dat, e;
      int          n_cmd, n_rsp;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld", {31'd0, rsp_valid}, 32'd0);
      chk("rst_dat", rsp_rdata, 32'd0);
      chk("rst_rdy", {31'd0, cmd_ready}, 32'd1);
      rst_n = 1'b1;

      // Fill the whole RAM so every later read has a known model value.
      for (int i = 0; i < 256; i++) txn(1'b0, 8'(i), 32'(i) * 32'h0101_0101, 4'hF, 32'd0, "init");

      vecs[0] = '{1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0};
      vecs[1] = '{1'b1, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 8'h10, 32'h11223344, 4'h5, 32'h0};
      vecs[3] = '{1'b1, 8'h10, 32'hFFFFFFFF, 4'hF, 32'hDE22BE44};
      vecs[4] = '{1'b0, 8'h10, 32'hFFFFFFFF, 4'h0, 32'h0};
      vecs[5] = '{1'b1, 8'h10, 32'h0,        4'h0, 32'hDE22BE44};
      vecs[6] = '{1'b0, 8'h20, 32'hA5A5A5A5, 4'h8, 32'h0};
      vecs[7] = '{1'b1, 8'h20, 32'h0,        4'h0, 32'hA5202020};
      foreach (vecs[i])
         txn(vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].wm, vecs[i].exp, $sformatf("vec%0d", i));

      // Back-to-back reads of 0..3 with rsp_ready high.
      @(posedge clk); #1;
      rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 8'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("b2b_rdy%0d", k), {31'd0, cmd_ready}, 32'd1);
         if (k > 0) begin
            chk($sformatf("b2b_vld%0d", k - 1), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("b2b_dat%0d", k - 1), rsp_rdata, 32'(k - 1) * 32'h0101_0101);
         end
         @(posedge clk); #1;
         cmd_addr = 8'(k + 1);
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("b2b_vld3", {31'd0, rsp_valid}, 32'd1);
      chk("b2b_dat3", rsp_rdata, 32'h0303_0303);
      @(posedge clk); #1;

      // Stall: response to 0x10 held 5 cycles while a read of 0x11 waits.
      rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 8'h10;
      @(posedge clk); #1;
      cmd_addr = 8'h11;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("stall_rdy%0d", k), {31'd0, cmd_ready}, 32'd0);
         chk($sformatf("stall_vld%0d", k), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("stall_dat%0d", k), rsp_rdata, 32'hDE22BE44);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("unstall_rdy", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("unstall_vld", {31'd0, rsp_valid}, 32'd1);
      chk("unstall_dat", rsp_rdata, 32'h1111_1111);
      @(posedge clk); #1;
      chk("unstall_idle", {31'd0, rsp_valid}, 32'd0);

      // Asynchronous reset while a response is pending.
      rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 8'h10;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("prerst_vld", {31'd0, rsp_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld", {31'd0, rsp_valid}, 32'd0);
      chk("arst_dat", rsp_rdata, 32'd0);
      chk("arst_rdy", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      txn(1'b1, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, "postrst");

      // Randomized traffic against the memory model.
      n_cmd = 0; n_rsp = 0; hold = 1'b0; stalled = 1'b0; prev_dat = '0;
      while (n_cmd < 400) begin
         @(posedge clk); #1;
         if (!hold) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_read  = $urandom_range(0, 1) == 1;
            cmd_addr  = 8'($urandom_range(0, 15));
            cmd_wdata = $urandom;
            cmd_wmask = 4'($urandom_range(0, 15));
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (stalled) begin
            chk("rnd_hold_vld", {31'd0, rsp_valid}, 32'd1);
            chk("rnd_hold_dat", rsp_rdata, prev_dat);
         end
         cf = cmd_valid & cmd_ready;
         rf = rsp_valid & rsp_ready;
         if (rf) begin
            if (expq.size() == 0) chk("rnd_extra_rsp", 32'd1, 32'd0);
            else begin
               e = expq.pop_front();
               chk("rnd_dat", rsp_rdata, e);
            end
            n_rsp++;
         end
         if (cf) begin
            if (cmd_read) expq.push_back(mdl[cmd_addr]);
            else begin
               mdl[cmd_addr] = merge(mdl[cmd_addr], cmd_wdata, cmd_wmask);
               expq.push_back(32'd0);
            end
            n_cmd++;
         end
         hold     = cmd_valid & ~cf;
         stalled  = rsp_valid & ~rsp_ready;
         prev_dat = rsp_rdata;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            if (expq.size() == 0) chk("drain_extra_rsp", 32'd1, 32'd0);
            else begin
               e = expq.pop_front();
               chk("drain_dat", rsp_rdata, e);
            end
            n_rsp++;
         end
         @(posedge clk); #1;
      end
      chk("rnd_count", 32'(n_rsp), 32'(n_cmd));
      chk("rnd_left", 32'(expq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
